// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
    } fifo_entry_t;

    // Low address bits that must be zero in a fetch address.
    localparam logic [1:0] INSN_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, registered count and a combinational head.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PC generation, pipelined imem
// requests, prefetch buffering and redirect flush with stale-response drop.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_insn_valid,
    output logic [XLEN-1:0] o_insn,
    output logic [XLEN-1:0] o_insn_pc,
    input  logic            i_insn_ready,
    output logic [XLEN-1:0] o_fetch_pc,
    output logic            o_proto_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   resp_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     discard;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     discard_next;
    logic [CW:0]       credit_used;
    logic [XLEN-1:0]   target;
    logic [2*XLEN-1:0] head;
    logic              proto_err;
    logic              granted;
    logic              resp_ok;
    logic              push;
    logic              pop;

    // In-flight requests and buffered entries share the FIFO's capacity.
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};

    assign o_imem_req = (state != S_BOOT) && !i_redirect &&
                        (credit_used < (CW+1)'(FIFO_DEPTH));
    assign o_imem_addr = fetch_pc;
    assign o_fetch_pc  = fetch_pc;
    assign o_proto_err = proto_err;

    assign granted = o_imem_req && i_imem_gnt;
    assign resp_ok = i_imem_rvalid && (outstanding != '0);
    assign push    = resp_ok && (discard == '0) && !i_redirect;
    assign pop     = o_insn_valid && i_insn_ready && !i_redirect;

    assign target = {i_redirect_pc[XLEN-1:2],
                     i_redirect_pc[1:0] & ~INSN_ALIGN_MASK};

    assign discard_next = outstanding + CW'(granted) - CW'(resp_ok);

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .flush     (i_redirect),
        .push      (push),
        .push_data ({i_imem_rdata, resp_pc}),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign o_insn_valid = (fifo_count != '0);
    assign o_insn       = o_insn_valid ? head[2*XLEN-1:XLEN] : '0;
    assign o_insn_pc    = o_insn_valid ? head[XLEN-1:0] : '0;

    // resp_pc is the PC of the next non-stale response, since imem is in order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_BOOT;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            proto_err   <= 1'b0;
        end else begin
            if (i_imem_rvalid && (outstanding == '0)) begin
                proto_err <= 1'b1;
            end
            outstanding <= outstanding + CW'(granted) - CW'(resp_ok);
            if (i_redirect) begin
                fetch_pc <= target;
                resp_pc  <= target;
                discard  <= discard_next;
                state    <= (discard_next != '0) ? S_DRAIN : S_RUN;
            end else begin
                if (granted) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (push) begin
                    resp_pc <= resp_pc + XLEN'(4);
                end
                if (resp_ok && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
                unique case (state)
                    S_BOOT: state <= S_RUN;
                    S_RUN:  state <= S_RUN;
                    S_DRAIN: begin
                        if ((discard == '0) ||
                            ((discard == CW'(1)) && resp_ok)) begin
                            state <= S_RUN;
                        end
                    end
                    default: state <= S_BOOT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: imem responder, stream-level model.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        insn_valid;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        ready = 1'b0;
    logic [31:0] fetch_pc;
    logic        proto_err;

    fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_gnt    (gnt),
        .i_imem_rvalid (rvalid),
        .i_imem_rdata  (rdata),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_insn_valid  (insn_valid),
        .o_insn        (insn),
        .o_insn_pc     (insn_pc),
        .i_insn_ready  (ready),
        .o_fetch_pc    (fetch_pc),
        .o_proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    // imem responder and reference model state
    logic [31:0] memq[$];
    bit          manual = 1'b1;
    int          gnt_pct = 100;
    int          rv_pct = 100;
    int          rdy_pct = 100;
    bit          boot = 1'b1;
    bit          perr = 1'b0;
    int          occ = 0;
    int          stale = 0;
    int          grants = 0;
    logic [31:0] exp_fetch = '0;
    logic [31:0] exp_dpc = '0;
    bit          m_gr;
    bit          m_rv;
    bit          m_req;

    always @(posedge clk) begin
        #1;
        if (!manual) begin
            gnt    = int'($urandom_range(99)) < gnt_pct;
            rvalid = !rst && (memq.size() > 0) &&
                     (int'($urandom_range(99)) < rv_pct);
            rdata  = rvalid ? mem_word(memq[0]) : 32'h0;
            ready  = int'($urandom_range(99)) < rdy_pct;
        end
    end

    // Model: address stream, delivered PC stream, buffered and stale counts.
    always @(negedge clk) begin
        if (rst) begin
            memq.delete();
            boot      = 1'b1;
            perr      = 1'b0;
            occ       = 0;
            stale     = 0;
            exp_fetch = 32'h0;
            exp_dpc   = 32'h0;
        end else begin
            m_req = !boot && !redirect && (memq.size() + occ < DEPTH);
            chk("req", 32'(imem_req), 32'(m_req));
            if (imem_req) chk("addr", imem_addr, exp_fetch);
            chk("fetch_pc", fetch_pc, exp_fetch);
            chk("valid", 32'(insn_valid), 32'(occ > 0));
            if (insn_valid && occ > 0) begin
                chk("insn_pc", insn_pc, exp_dpc);
                chk("insn", insn, mem_word(exp_dpc));
            end
            chk("proto_err", 32'(proto_err), 32'(perr));
            m_gr = imem_req && gnt;
            m_rv = rvalid && (memq.size() > 0);
            if (rvalid && memq.size() == 0) perr = 1'b1;
            if (redirect) begin
                exp_fetch = {redirect_pc[31:2], 2'b00};
                exp_dpc   = {redirect_pc[31:2], 2'b00};
                occ       = 0;
                stale     = memq.size() + (m_gr ? 1 : 0) - (m_rv ? 1 : 0);
            end else begin
                if (m_gr) begin
                    exp_fetch = exp_fetch + 32'd4;
                    grants++;
                end
                if (insn_valid && ready && occ > 0) begin
                    occ--;
                    exp_dpc = exp_dpc + 32'd4;
                end
                if (m_rv) begin
                    if (stale > 0) stale--;
                    else occ++;
                end
            end
            if (m_gr) memq.push_back(imem_addr);
            if (m_rv) void'(memq.pop_front());
            boot = 1'b0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        manual = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        redirect = 1'b0; ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(insn_valid), 32'h0);
        chk("rst_insn", insn, 32'h0);
        chk("rst_insn_pc", insn_pc, 32'h0);
        chk("rst_err", 32'(proto_err), 32'h0);
        chk("rst_fetch_pc", fetch_pc, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic step(input bit g, input bit rv, input bit rdy,
                        input bit rd, input logic [31:0] rpc);
        @(posedge clk); #1;
        gnt         = g;
        rvalid      = rv;
        rdata       = (rv && memq.size() > 0) ? mem_word(memq[0]) : 32'h0;
        ready       = rdy;
        redirect    = rd;
        redirect_pc = rpc;
    endtask

    task automatic redir(input logic [31:0] pc);
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = pc;
        @(posedge clk); #1;
        redirect = 1'b0;
    endtask

    typedef struct {
        logic [31:0] tgt;
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int g0;
        bit seen;
        vecs[0] = '{32'h0000_0102, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204};
        vecs[2] = '{32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{32'h7FFF_FFFE, 32'h7FFF_FFFC, 32'h8000_0000};

        // zero-wait start-up stream
        do_reset();
        gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
        manual = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk); #1;
            if (insn_valid) seen = 1'b1;
        end
        chk("t1_first_valid", 32'(seen), 32'h1);
        chk("t1_pc0", insn_pc, 32'h0);
        @(negedge clk); #1;
        chk("t1_valid1", 32'(insn_valid), 32'h1);
        chk("t1_pc1", insn_pc, 32'h4);
        @(negedge clk); #1;
        chk("t1_valid2", 32'(insn_valid), 32'h1);
        chk("t1_pc2", insn_pc, 32'h8);

        // decode stalled: credit limit
        @(negedge clk);
        rdy_pct = 0;
        redir(32'h0);
        g0 = grants;
        repeat (12) @(negedge clk);
        #1;
        chk("t2_grants", 32'(grants - g0), 32'd4);
        chk("t2_req_low", 32'(imem_req), 32'h0);
        chk("t2_head_pc", insn_pc, 32'h0);
        rdy_pct = 100;
        repeat (10) @(negedge clk);

        // redirect with 2 outstanding and a same-cycle response
        do_reset();
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(0, 1, 1, 1, 32'h0000_0102);
        @(negedge clk); #1;
        chk("t3_req_redir", 32'(imem_req), 32'h0);
        step(1, 1, 1, 0, 0);
        @(negedge clk); #1;
        chk("t3_addr", imem_addr, 32'h100);
        step(1, 1, 1, 0, 0);
        @(negedge clk); #1;
        chk("t3_no_stale", 32'(insn_valid), 32'h0);
        step(0, 0, 1, 0, 0);
        @(negedge clk); #1;
        chk("t3_valid", 32'(insn_valid), 32'h1);
        chk("t3_pc", insn_pc, 32'h100);
        manual = 1'b0;
        repeat (8) @(negedge clk);

        // grant withheld, then redirect
        do_reset();
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1, 0, 0);
            @(negedge clk); #1;
            chk("t4_hold_req", 32'(imem_req), 32'h1);
            chk("t4_hold_addr", imem_addr, 32'h8);
        end
        step(0, 0, 1, 1, 32'h0000_0200);
        @(negedge clk); #1;
        chk("t4_req_drop", 32'(imem_req), 32'h0);
        step(1, 0, 1, 0, 0);
        @(negedge clk); #1;
        chk("t4_req_new", 32'(imem_req), 32'h1);
        chk("t4_addr_new", imem_addr, 32'h200);
        manual = 1'b0;
        repeat (10) @(negedge clk);

        // redirect alignment and address wrap
        gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
        for (int i = 0; i < 4; i++) begin
            redir(vecs[i].tgt);
            @(negedge clk); #1;
            chk("tv_target", fetch_pc, vecs[i].exp_pc);
            @(negedge clk); #1;
            chk("tv_next", fetch_pc, vecs[i].exp_next);
            repeat (4) @(negedge clk);
        end

        // response with nothing outstanding
        do_reset();
        step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        @(negedge clk); #1;
        chk("t6_err_set", 32'(proto_err), 32'h1);
        repeat (3) step(0, 0, 1, 0, 0);
        @(negedge clk); #1;
        chk("t6_err_sticky", 32'(proto_err), 32'h1);
        do_reset();

        // randomized traffic, with one mid-run reset
        manual = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                gnt_pct = 30 + int'($urandom_range(70));
                rv_pct  = 30 + int'($urandom_range(70));
                rdy_pct = 20 + int'($urandom_range(80));
            end
            if (c == 2000) begin
                do_reset();
                manual = 1'b0;
            end
            @(posedge clk); #1;
            redirect = int'($urandom_range(99)) < 4;
            redirect_pc = $urandom;
            if ($urandom_range(3) == 0)
                redirect_pc = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
        end
        @(posedge clk); #1;
        redirect = 1'b0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
